multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/cond_eval.sv | 32 +++
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the multicycle controller:
//   - FSM state encoding (state_t)
//   - instruction class codes carried on op_class
//   - branch condition codes carried on cond
//   - small decode helpers used by the controller
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   localparam logic [2:0] OP_ALU_R  = 3'd0;
   localparam logic [2:0] OP_ALU_I  = 3'd1;
   localparam logic [2:0] OP_LOAD   = 3'd2;
   localparam logic [2:0] OP_STORE  = 3'd3;
   localparam logic [2:0] OP_BRANCH = 3'd4;
   localparam logic [2:0] OP_JUMP   = 3'd5;
   localparam logic [2:0] OP_HALT   = 3'd6;
   localparam logic [2:0] OP_NOP    = 3'd7;

   // Code 0 is not named: it behaves as GREATER.
   localparam logic [1:0] COND_LESS    = 2'd1;
   localparam logic [1:0] COND_GREATER = 2'd2;
   localparam logic [1:0] COND_EQUAL   = 2'd3;

   // Classes whose ALU B operand is the immediate (address calc for memory ops).
   function automatic logic uses_imm(input logic [2:0] cls);
      return (cls == OP_ALU_I) || (cls == OP_LOAD) || (cls == OP_STORE);
   endfunction

   function automatic logic is_mem(input logic [2:0] cls);
      return (cls == OP_LOAD) || (cls == OP_STORE);
   endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval
// Evaluates a branch condition against a two's-complement operand.
// Ports:
//   operand : WIDTH-bit signed value under test
//   cond    : condition code (LESS, EQUAL, GREATER; 0 acts as GREATER)
//   taken   : 1 when the condition holds
module cond_eval
   import ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] operand,
   input  logic [1:0]       cond,
   output logic             taken
);

   logic is_neg_s;
   logic is_zero_s;

   // Sign/zero classification of the operand and condition selection.
   always_comb begin
      is_neg_s  = operand[WIDTH-1];
      is_zero_s = (operand == {WIDTH{1'b0}});
      case (cond)
         COND_LESS:    taken = is_neg_s;
         COND_EQUAL:   taken = is_zero_s;
         COND_GREATER: taken = ~is_neg_s & ~is_zero_s;
         default:      taken = ~is_neg_s & ~is_zero_s;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM of a multicycle processor: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   op_class, cond           : instruction class / branch condition from the IR,
//                              latched during DECODE
//   br_operand               : signed value tested by branches (sampled live in EXEC)
//   imem_ready, dmem_ready   : memory handshakes, honoured only in FETCH / MEM
//   imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
//   alu_src_sel, reg_we, wb_sel : datapath strobes/selects (combinational)
//   halted                   : high while in HALTED
//   retired                  : count of completed instructions, wraps at 2^32
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op_class,
   input  logic [1:0]       cond,
   input  logic [WIDTH-1:0] br_operand,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             alu_src_sel,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             halted,
   output logic [31:0]      retired
);

   state_t     state_r;
   state_t     state_s;
   logic [2:0] class_r;
   logic [1:0] cond_r;
   logic       taken_s;
   logic       retire_s;

   cond_eval #(
      .WIDTH(WIDTH)
   ) u_cond_eval (
      .operand(br_operand),
      .cond   (cond_r),
      .taken  (taken_s)
   );

   // State register plus the class/cond latch loaded while in DECODE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_FETCH;
         class_r <= 3'd0;
         cond_r  <= 2'd0;
      end else begin
         state_r <= state_s;
         if (state_r == S_DECODE) begin
            class_r <= op_class;
            cond_r  <= cond;
         end
      end
   end

   // Retired-instruction counter; retire_s marks the final cycle of an instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired <= 32'd0;
      end else if (retire_s) begin
         retired <= retired + 32'd1;
      end
   end

   // Next-state and output decode. While rst is high every output is held
   // at 0 so that no strobe (including imem_req) escapes during reset.
   always_comb begin
      state_s     = state_r;
      retire_s    = 1'b0;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      alu_src_sel = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = 1'b0;
      halted      = 1'b0;
      if (rst) begin
         state_s = S_FETCH;
      end else begin
         case (state_r)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  pc_sel  = 1'b0;
                  state_s = S_DECODE;
               end else begin
                  state_s = S_FETCH;
               end
            end
            S_DECODE: begin
               state_s = S_EXEC;
            end
            S_EXEC: begin
               alu_src_sel = uses_imm(class_r);
               case (class_r)
                  OP_ALU_R, OP_ALU_I: begin
                     state_s = S_WB;
                  end
                  OP_LOAD, OP_STORE: begin
                     state_s = S_MEM;
                  end
                  OP_BRANCH: begin
                     pc_we    = taken_s;
                     pc_sel   = taken_s;
                     retire_s = 1'b1;
                     state_s  = S_FETCH;
                  end
                  OP_JUMP: begin
                     pc_we    = 1'b1;
                     pc_sel   = 1'b1;
                     retire_s = 1'b1;
                     state_s  = S_FETCH;
                  end
                  OP_HALT: begin
                     retire_s = 1'b1;
                     state_s  = S_HALTED;
                  end
                  default: begin
                     retire_s = 1'b1;
                     state_s  = S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (class_r == OP_STORE);
               if (dmem_ready) begin
                  if (class_r == OP_LOAD) begin
                     state_s = S_WB;
                  end else begin
                     retire_s = 1'b1;
                     state_s  = S_FETCH;
                  end
               end else begin
                  state_s = S_MEM;
               end
            end
            S_WB: begin
               reg_we   = 1'b1;
               wb_sel   = (class_r == OP_LOAD);
               retire_s = 1'b1;
               state_s  = S_FETCH;
            end
            S_HALTED: begin
               halted  = 1'b1;
               state_s = S_HALTED;
            end
            default: begin
               state_s = S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Self-checking bench: directed table of single instructions, hand-written
// multi-cycle sequences, and a randomized instruction stream checked cycle by
// cycle against an instruction-level reference model.
module tb_multicycle_controller;
   import ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic [2:0]  op_class;
   logic [1:0]  cond;
   logic [31:0] br_operand;
   logic        imem_ready;
   logic        dmem_ready;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel;
   logic        alu_src_sel, reg_we, wb_sel, halted;
   logic [31:0] retired;

   int tests  = 0;
   int failed = 0;
   int ret_model = 0;

   localparam logic [9:0] M_IREQ  = 10'b1000000000;
   localparam logic [9:0] M_DREQ  = 10'b0100000000;
   localparam logic [9:0] M_DWE   = 10'b0010000000;
   localparam logic [9:0] M_IRWE  = 10'b0001000000;
   localparam logic [9:0] M_PCWE  = 10'b0000100000;
   localparam logic [9:0] M_PCSEL = 10'b0000010000;
   localparam logic [9:0] M_ALU   = 10'b0000001000;
   localparam logic [9:0] M_REGWE = 10'b0000000100;
   localparam logic [9:0] M_WBSEL = 10'b0000000010;
   localparam logic [9:0] M_HALT  = 10'b0000000001;

   wire [9:0] obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
                     alu_src_sel, reg_we, wb_sel, halted};

   multicycle_controller #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .op_class(op_class), .cond(cond),
      .br_operand(br_operand), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_sel(alu_src_sel),
      .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [2:0]  cls;
      logic [1:0]  cnd;
      logic [31:0] opnd;
      logic        exp_alu;
      logic        exp_pc;
      int          exp_lat;
      logic        exp_reg;
      logic        exp_wb;
      logic        exp_dwe;
      logic        exp_halt;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: sample outputs and retired mid-cycle, then advance.
   task automatic step(input logic [9:0] exp, input string name);
      @(negedge clk);
      chk(name, {22'd0, retired, obs}, {22'd0, ret_model[31:0], exp});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      op_class = 3'd0;
      cond = 2'd0;
      br_operand = 32'd0;
      @(negedge clk);
      chk("reset_outputs", {54'd0, obs}, 64'd0);
      chk("reset_retired", {32'd0, retired}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      ret_model = 0;
   endtask

   // Reference model: expected trace of one instruction from its class,
   // condition, operand and the memory wait counts.
   task automatic model_instr(input logic [2:0] cls, input logic [1:0] cnd,
                              input logic signed [31:0] opnd,
                              input int fwait, input int mwait);
      logic [9:0] e;
      logic       tk;
      for (int i = 0; i < fwait; i++) begin
         imem_ready = 1'b0;
         dmem_ready = 1'($urandom);
         op_class = 3'($urandom);
         cond = 2'($urandom);
         step(M_IREQ, "fetch_wait");
      end
      imem_ready = 1'b1;
      step(M_IREQ | M_IRWE | M_PCWE, "fetch");
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      op_class = cls;
      cond = cnd;
      step(10'd0, "decode");
      op_class = 3'($urandom);
      cond = 2'($urandom);
      br_operand = opnd;
      tk = (cnd == 2'd1) ? (opnd < 0) : (cnd == 2'd3) ? (opnd == 0) : (opnd > 0);
      e = 10'd0;
      if (cls == 3'd1 || cls == 3'd2 || cls == 3'd3) e = e | M_ALU;
      if (cls == 3'd5 || (cls == 3'd4 && tk)) e = e | M_PCWE | M_PCSEL;
      step(e, "exec");
      if (cls == 3'd2 || cls == 3'd3) begin
         e = (cls == 3'd3) ? (M_DREQ | M_DWE) : M_DREQ;
         for (int i = 0; i < mwait; i++) begin
            dmem_ready = 1'b0;
            imem_ready = 1'($urandom);
            step(e, "mem_wait");
         end
         dmem_ready = 1'b1;
         step(e, "mem_done");
      end
      if (cls <= 3'd2) begin
         dmem_ready = 1'($urandom);
         imem_ready = 1'($urandom);
         step((cls == 3'd2) ? (M_REGWE | M_WBSEL) : M_REGWE, "wb");
      end
      ret_model++;
      if (cls == 3'd6) begin
         for (int i = 0; i < 4; i++) begin
            imem_ready = 1'($urandom);
            step(M_HALT, "halted");
         end
      end
   endtask

   // Table entry: zero-wait memories; measures latency until the DUT is back
   // in FETCH (or HALTED) and captures the per-stage strobes.
   task automatic run_entry(input vec_t v, input int idx);
      int   lat;
      logic done, saw_reg, saw_wb, saw_dwe;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      op_class = ~v.cls;
      @(negedge clk);
      chk($sformatf("tbl%0d_irwe", idx), {63'd0, ir_we}, 64'd1);
      @(posedge clk); #1;
      imem_ready = 1'b0;
      op_class = v.cls;
      cond = v.cnd;
      br_operand = v.opnd;
      @(posedge clk); #1;
      op_class = ~v.cls;
      cond = ~v.cnd;
      @(negedge clk);
      chk($sformatf("tbl%0d_alu_src", idx), {63'd0, alu_src_sel}, {63'd0, v.exp_alu});
      chk($sformatf("tbl%0d_pc", idx), {62'd0, pc_we, pc_sel}, {62'd0, v.exp_pc, v.exp_pc});
      @(posedge clk); #1;
      lat = 3;
      done = 1'b0;
      saw_reg = 1'b0;
      saw_wb = 1'b0;
      saw_dwe = 1'b0;
      for (int k = 0; k < 12 && !done; k++) begin
         @(negedge clk);
         if (imem_req || halted) begin
            done = 1'b1;
         end else begin
            lat++;
            if (reg_we) begin
               saw_reg = 1'b1;
               saw_wb = wb_sel;
            end
            if (dmem_we) saw_dwe = 1'b1;
            @(posedge clk); #1;
         end
      end
      chk($sformatf("tbl%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
      chk($sformatf("tbl%0d_reg_we", idx), {63'd0, saw_reg}, {63'd0, v.exp_reg});
      chk($sformatf("tbl%0d_wb_sel", idx), {63'd0, saw_wb}, {63'd0, v.exp_wb});
      chk($sformatf("tbl%0d_dmem_we", idx), {63'd0, saw_dwe}, {63'd0, v.exp_dwe});
      chk($sformatf("tbl%0d_halted", idx), {63'd0, halted}, {63'd0, v.exp_halt});
      ret_model++;
      chk($sformatf("tbl%0d_retired", idx), {32'd0, retired}, 64'(ret_model));
      @(posedge clk); #1;
   endtask

   initial begin
      int first_ir, first_reg, dreq_cnt;
      logic wb_at_reg, dwe_seen;
      logic [31:0] ret_c5;
      logic [2:0]  rc;
      logic [31:0] ro;

      rst = 1'b1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      op_class = 3'd0;
      cond = 2'd0;
      br_operand = 32'd0;

      //                cls   cnd   operand        alu   pc    lat reg   wb    dwe   halt
      tbl[0]  = '{3'd0, 2'd0, 32'd0,         1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{3'd1, 2'd0, 32'd0,         1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{3'd2, 2'd0, 32'd0,         1'b1, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{3'd3, 2'd0, 32'd0,         1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{3'd4, 2'd1, 32'hFFFFFFFB,  1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{3'd4, 2'd1, 32'd0,         1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{3'd4, 2'd3, 32'd0,         1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{3'd4, 2'd3, 32'd4,         1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{3'd4, 2'd0, 32'd7,         1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{3'd4, 2'd2, 32'hFFFFFFFF,  1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{3'd4, 2'd2, 32'h7FFFFFFF,  1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{3'd4, 2'd1, 32'h80000000,  1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{3'd5, 2'd0, 32'd0,         1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{3'd7, 2'd1, 32'hFFFFFFFF,  1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{3'd6, 2'd0, 32'd0,         1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1};

      // ALU_R straight after reset with imem_ready tied high.
      do_reset();
      imem_ready = 1'b1;
      op_class = OP_ALU_R;
      first_ir = 0;
      first_reg = 0;
      wb_at_reg = 1'b1;
      ret_c5 = 32'hDEADBEEF;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (ir_we && first_ir == 0) first_ir = c;
         if (reg_we && first_reg == 0) begin
            first_reg = c;
            wb_at_reg = wb_sel;
         end
         if (c == 5) ret_c5 = retired;
         @(posedge clk); #1;
      end
      chk("alu_ir_we_cycle", 64'(first_ir), 64'd1);
      chk("alu_reg_we_cycle", 64'(first_reg), 64'd4);
      chk("alu_wb_sel", {63'd0, wb_at_reg}, 64'd0);
      chk("alu_retired", {32'd0, ret_c5}, 64'd1);

      // Directed table.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         run_entry(tbl[i], i);
         if (tbl[i].exp_halt) do_reset();
      end

      // LOAD with dmem_ready delayed three cycles.
      do_reset();
      imem_ready = 1'b1;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      op_class = OP_LOAD;
      @(posedge clk); #1;
      op_class = OP_STORE;
      @(posedge clk); #1;
      dreq_cnt = 0;
      dwe_seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         dmem_ready = (k == 3);
         @(negedge clk);
         if (dmem_req) dreq_cnt++;
         if (dmem_we) dwe_seen = 1'b1;
         if (k == 4) chk("load_wb", {62'd0, reg_we, wb_sel}, 64'd3);
         @(posedge clk); #1;
      end
      chk("load_dmem_req_cycles", 64'(dreq_cnt), 64'd4);
      chk("load_dmem_we", {63'd0, dwe_seen}, 64'd0);
      @(negedge clk);
      chk("load_retired", {32'd0, retired}, 64'd1);
      @(posedge clk); #1;

      // HALT is absorbing even with imem_ready held high.
      do_reset();
      model_instr(OP_HALT, 2'd0, 32'sd0, 0, 0);
      imem_ready = 1'b1;
      for (int k = 0; k < 10; k++) step(M_HALT, "halt_absorb");

      // Reset asserted in the middle of a STORE's memory wait.
      do_reset();
      model_instr(OP_ALU_R, 2'd0, 32'sd0, 0, 0);
      imem_ready = 1'b1;
      step(M_IREQ | M_IRWE | M_PCWE, "st_fetch");
      imem_ready = 1'b0;
      op_class = OP_STORE;
      step(10'd0, "st_decode");
      step(M_ALU, "st_exec");
      dmem_ready = 1'b0;
      step(M_DREQ | M_DWE, "st_mem");
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_mem_outputs", {54'd0, obs}, 64'd0);
      chk("rst_mid_mem_retired", {32'd0, retired}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ret_model = 0;
      @(negedge clk);
      chk("fetch_after_rst", {54'd0, obs}, {54'd0, M_IREQ});
      @(posedge clk); #1;

      // Randomized instruction stream against the model.
      do_reset();
      for (int n = 0; n < 200; n++) begin
         rc = 3'($urandom_range(0, 7));
         if (rc == OP_HALT && $urandom_range(0, 3) != 0) rc = OP_NOP;
         case ($urandom_range(0, 3))
            0:       ro = 32'd0;
            1:       ro = 32'($urandom_range(0, 6)) - 32'd3;
            2:       ro = $urandom;
            default: ro = 32'h80000000;
         endcase
         model_instr(rc, 2'($urandom_range(0, 3)), ro,
                     $urandom_range(0, 3), $urandom_range(0, 3));
         if (rc == OP_HALT) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
